// File: rtl/pwm_duty_ramp.sv
// Soft-start duty sequencer: ramps duty_out toward a loaded target, one LSB per PRESCALE clocks.
// Define PWM_RAMP_DOWN_EN for symmetric ramp-down; otherwise lower targets apply at once.
module pwm_duty_ramp #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] target_in,
    input  logic             load_in,
    input  logic             enable_in,
    output logic [WIDTH-1:0] duty_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_d;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] tgt_d;
    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic [WIDTH-1:0] duty_step;
    logic             step_done;
    logic             fast_off;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            presc_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            presc_q <= presc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Steps always head toward the target, so the result never wraps.
    always_comb begin
        duty_step = duty_q;
        if (tgt_q > duty_q) begin
            duty_step = duty_q + WIDTH'(1);
        end else if (tgt_q < duty_q) begin
            duty_step = duty_q - WIDTH'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        tgt_d     = tgt_q;
        presc_d   = presc_q;
        step_done = 1'b0;
        fast_off  = 1'b0;
        if (load_in) begin
            tgt_d   = target_in;
            presc_d = '0;
            if (target_in == duty_q) begin
                state_d = IDLE;
`ifdef PWM_RAMP_DOWN_EN
            end else begin
                state_d = RAMP;
            end
`else
            end else if (target_in > duty_q) begin
                state_d = RAMP;
            end else begin
                duty_d   = target_in;
                state_d  = IDLE;
                fast_off = 1'b1;
            end
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    presc_d = '0;
                end
                RAMP: begin
                    if (enable_in) begin
                        if (presc_q == P_LAST) begin
                            presc_d = '0;
                            duty_d  = duty_step;
                            if (duty_step == tgt_q) begin
                                state_d   = IDLE;
                                step_done = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy_d = (state_d == RAMP);
        done_d = step_done | fast_off;
    end

    assign duty_out = duty_q;
    assign busy_out = busy_q;
    assign done_out = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: vector table plus multi-cycle sequences.
// Expectations follow the build's PWM_RAMP_DOWN_EN setting.
module tb_pwm_duty_ramp;

    logic       clk_in;
    logic       rst_n_in;
    logic [3:0] target_in;
    logic       load_in;
    logic       enable_in;
    logic [3:0] duty_out;
    logic       busy_out;
    logic       done_out;

    int n_cmp;
    int n_bad;

    pwm_duty_ramp #(.WIDTH(4), .PRESCALE(16)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .target_in (target_in),
        .load_in   (load_in),
        .enable_in (enable_in),
        .duty_out  (duty_out),
        .busy_out  (busy_out),
        .done_out  (done_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        string      name;
        logic       load;
        logic [3:0] tgt;
        logic       en;
        int         n;
        logic [3:0] duty;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(string nm, logic ld, logic [3:0] t, logic e,
                                int n, logic [3:0] d, logic b, logic dn);
        vec_t v;
        v.name = nm;
        v.load = ld;
        v.tgt  = t;
        v.en   = e;
        v.n    = n;
        v.duty = d;
        v.busy = b;
        v.done = dn;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk3(string nm, int d, int b, int dn);
        chk({nm, ".duty"}, int'(duty_out), d);
        chk({nm, ".busy"}, int'(busy_out), b);
        chk({nm, ".done"}, int'(done_out), dn);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        #2;
        rst_n_in = 1'b1;
        tick();
    endtask

    task automatic load(logic [3:0] t);
        load_in   = 1'b1;
        target_in = t;
        tick();
        load_in   = 1'b0;
    endtask

    initial begin
        int waited;
        n_cmp     = 0;
        n_bad     = 0;
        rst_n_in  = 1'b0;
        load_in   = 1'b0;
        target_in = '0;
        enable_in = 1'b1;

        vecs[0] = mk("up_load",   1, 10, 1, 1,   0,  1, 0);
        vecs[1] = mk("up_pre",    0, 0,  1, 15,  0,  1, 0);
        vecs[2] = mk("up_step1",  0, 0,  1, 1,   1,  1, 0);
        vecs[3] = mk("up_edge159",0, 0,  1, 143, 9,  1, 0);
        vecs[4] = mk("up_done",   0, 0,  1, 1,   10, 0, 1);
        vecs[5] = mk("up_after",  0, 0,  1, 1,   10, 0, 0);
        vecs[6] = mk("null_load", 1, 10, 1, 1,   10, 0, 0);
`ifdef PWM_RAMP_DOWN_EN
        vecs[7]  = mk("dn_load",  1, 3,  1, 1,   10, 1, 0);
        vecs[8]  = mk("dn_l1",    0, 0,  1, 1,   10, 1, 0);
        vecs[9]  = mk("dn_l111",  0, 0,  1, 110, 4,  1, 0);
        vecs[10] = mk("dn_done",  0, 0,  1, 1,   3,  0, 1);
`else
        vecs[7]  = mk("dn_load",  1, 3,  1, 1,   3,  0, 1);
        vecs[8]  = mk("dn_l1",    0, 0,  1, 1,   3,  0, 0);
        vecs[9]  = mk("dn_l111",  0, 0,  1, 110, 3,  0, 0);
        vecs[10] = mk("dn_l112",  0, 0,  1, 1,   3,  0, 0);
`endif

        #12;
        chk3("reset", 0, 0, 0);
        rst_n_in = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            load_in   = vecs[i].load;
            target_in = vecs[i].tgt;
            enable_in = vecs[i].en;
            tick();
            load_in = 1'b0;
            run(vecs[i].n - 1);
            chk3(vecs[i].name, int'(vecs[i].duty), int'(vecs[i].busy),
                 int'(vecs[i].done));
        end

        // Freeze at duty 5 for 40 cycles; completion slips from 160 to 200.
        do_reset();
        enable_in = 1'b1;
        load(10);
        run(80);
        chk3("frz_e80", 5, 1, 0);
        enable_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0 || i == 39) chk3("frz_hold", 5, 1, 0);
        end
        enable_in = 1'b1;
        waited = 0;
        while (done_out !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        chk("frz_wait", waited, 80);
        chk3("frz_done", 10, 0, 1);

        // Retarget from duty 4 down to 2.
        do_reset();
        load(10);
        run(64);
        chk("rt_at4", int'(duty_out), 4);
        load(2);
`ifdef PWM_RAMP_DOWN_EN
        chk3("rt_load", 4, 1, 0);
        run(15);
        chk3("rt_l15", 4, 1, 0);
        tick();
        chk3("rt_l16", 3, 1, 0);
        run(15);
        chk3("rt_l31", 3, 1, 0);
        tick();
        chk3("rt_l32", 2, 0, 1);
`else
        chk3("rt_load", 2, 0, 1);
        tick();
        chk3("rt_l1", 2, 0, 0);
`endif

        // Asynchronous reset between edges mid-ramp.
        do_reset();
        load(10);
        run(96);
        chk3("rst_at6", 6, 1, 0);
        rst_n_in = 1'b0;
        #2;
        chk3("rst_async", 0, 0, 0);
        #2;
        rst_n_in = 1'b1;
        tick();
        load(2);
        run(31);
        chk3("rst_l31", 1, 1, 0);
        tick();
        chk3("rst_l32", 2, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
